pia_bus_master: RTL
===================

Name: pia_bus_master

Overview:
- Bus initiator for the 7-bit-address / 8-bit-data peripheral strobe bus used by the PIA and sibling peripherals.
- Accepts write, read and poll commands from a host (debug/OSD sequencer) over a valid/ready handshake.
- Issues single-cycle strobe bus cycles and returns read data on a one-cycle response pulse.
- Poll command re-reads an address until a masked compare matches or a retry limit expires, e.g. waiting on INSTAT underflow.

Parameters:
RD_LATENCY, 1, cycles from strobe cycle to the cycle in which dat_i is valid (1..4)
POLL_GAP, 4, idle cycles between successive poll reads (0..15)
POLL_TIMEOUT, 1024, max non-matching poll reads before timeout response (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_op_i  in  2  00 write, 01 read, 10 poll, 11 reserved
cmd_adr_i  in  7  target address
cmd_dat_i  in  8  write data / poll compare value
cmd_mask_i  in  8  poll compare mask
abort_i  in  1  abort an in-progress poll
stb_o  out  1  bus strobe
we_o  out  1  bus write enable
adr_o  out  7  bus address
dat_o  out  8  bus write data
dat_i  in  8  bus read data
rsp_valid_o  out  1  response pulse
rsp_dat_o  out  8  read/poll data
rsp_timeout_o  out  1  poll ended without match (timeout or abort)
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except cmd_ready_o=1. Poll counter and abort latch cleared. Bus cycle in progress is dropped immediately.
- States: IDLE, STROBE, WAIT, GAP, RESP.
- IDLE: cmd_ready_o=1, busy_o=0. On cmd_valid_i & cmd_ready_o, latch op/adr/dat/mask and go to STROBE. Exception: op 11 is accepted and discarded, stays IDLE, no bus cycle, no response.
- cmd_ready_o=0 in all states except IDLE. cmd_valid_i is ignored while not ready.
- STROBE (exactly 1 cycle):
  - stb_o=1, adr_o=latched adr.
  - Write: we_o=1, dat_o=latched data, next state IDLE, no response.
  - Read/poll: we_o=0, dat_o=0, next state WAIT.
- stb_o, we_o, adr_o, dat_o are 0 outside STROBE.
- WAIT: lasts RD_LATENCY cycles. On the last WAIT cycle, dat_i is sampled into the capture register.
  - Read: go to RESP.
  - Poll: compare (dat_i & mask) == (cmd_dat & mask).
    - Match: go to RESP with timeout=0.
    - Mismatch: increment poll count. If count reaches POLL_TIMEOUT, or abort is latched, go to RESP with timeout=1. Otherwise go to GAP.
- GAP: POLL_GAP cycles, then STROBE. With POLL_GAP=0, STROBE follows WAIT directly. If abort_i is seen in GAP, go to RESP with timeout=1 on the next cycle.
- abort_i during STROBE/WAIT of a poll is latched and acted on at the end of WAIT. A match in that same cycle wins (timeout=0).
- abort_i has no effect in IDLE or for read/write commands.
- RESP (1 cycle): rsp_valid_o=1, rsp_dat_o=captured data, rsp_timeout_o as decided. Next state IDLE.
- rsp_dat_o and rsp_timeout_o hold their values until the next response. rsp_valid_o is 0 except in RESP.
- Timing with handshake in cycle 0:
  - Write: stb cycle 1, ready again cycle 2.
  - Read: stb cycle 1, dat_i sampled in cycle 1+RD_LATENCY, rsp_valid_o in cycle 2+RD_LATENCY.
  - Poll read period: 1+RD_LATENCY+POLL_GAP cycles.
- Poll counter width: clog2(POLL_TIMEOUT+1). It is cleared on command acceptance and never wraps.
- Reset mid-poll: no response is issued. After release, the block is IDLE and ready.

Test Plan:
- Write op, adr 0x15, dat 0x40 -> cycle 1: stb_o=1, we_o=1, adr_o=0x15, dat_o=0x40. cmd_ready_o=1 in cycle 2. No rsp_valid_o.
- Read adr 0x04, bench returns 0x3C one cycle after strobe -> exactly one strobe with we_o=0. rsp_valid_o=1 in cycle 3 with rsp_dat_o=0x3C, rsp_timeout_o=0.
- Poll adr 0x05, mask 0x80, value 0x80, bench sets bit7 (data 0xC0) on the 3rd read -> 3 strobes spaced 6 cycles apart. Response rsp_dat_o=0xC0, timeout=0.
- POLL_TIMEOUT=4, poll never matches (data 0x00) -> exactly 4 strobes. Response timeout=1, rsp_dat_o=0x00.
- abort_i pulsed during GAP after the 2nd poll read -> rsp_valid_o next cycle with timeout=1. No 3rd strobe.
- rst_ni low during WAIT of a poll -> stb_o/busy_o immediately 0, no response. After release, a read command completes normally. cmd_valid_i held during a busy poll is not accepted until the cycle after RESP.

Source files
------------

// File: rtl/pia_bus_master_if.sv
// Host command, peripheral strobe bus and response signals of pia_bus_master.
// master is the initiator's view; slave is the host/peripheral side view.
interface pia_bus_master_if;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [1:0] cmd_op_i;
  logic [6:0] cmd_adr_i;
  logic [7:0] cmd_dat_i;
  logic [7:0] cmd_mask_i;
  logic       abort_i;
  logic       stb_o;
  logic       we_o;
  logic [6:0] adr_o;
  logic [7:0] dat_o;
  logic [7:0] dat_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_dat_o;
  logic       rsp_timeout_o;
  logic       busy_o;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i, cmd_mask_i, abort_i, dat_i,
    output cmd_ready_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_dat_o,
           rsp_timeout_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_adr_i, cmd_dat_i, cmd_mask_i, abort_i, dat_i,
    input  cmd_ready_o, stb_o, we_o, adr_o, dat_o, rsp_valid_o, rsp_dat_o,
           rsp_timeout_o, busy_o
  );
endinterface

// File: rtl/pia_bus_master.sv
// Strobe-bus initiator for the PIA peripheral bus: write, read and masked-compare
// poll commands. Every output is a flop loaded from the next-state decode.
module pia_bus_master #(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  pia_bus_master_if.master   bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned PCNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam int unsigned ADR_W  = 7;
  localparam int unsigned DAT_W  = 8;

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_POLL = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_GAP,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [ADR_W-1:0]   cadr_q, cadr_d;
  logic [DAT_W-1:0]   cdat_q, cdat_d;
  logic [DAT_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               abort_q, abort_d;
  logic [DAT_W-1:0]   cap_q, cap_d;

  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               stb_q, stb_d;
  logic               we_q, we_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [DAT_W-1:0]   wdat_q, wdat_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_to_q, rsp_to_d;

  logic [PCNT_W-1:0]  pcnt_inc_c;
  logic               hit_c;
  logic               limit_c;

  assign pcnt_inc_c = pcnt_q + PCNT_W'(1);
  assign limit_c    = (pcnt_inc_c == PCNT_W'(POLL_TIMEOUT));
  assign hit_c      = ((bus.dat_i ^ cdat_q) & mask_q) == DAT_W'(0);

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cadr_d   = cadr_q;
    cdat_d   = cdat_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    abort_d  = abort_q;
    cap_d    = cap_q;
    rsp_to_d = rsp_to_q;

    // Abort during the bus phase of a poll is held until the read completes
    if (op_q == OP_POLL && (state_q == S_STROBE || state_q == S_WAIT) && bus.abort_i) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i && ready_q && bus.cmd_op_i != 2'b11) begin
          op_d    = bus.cmd_op_i;
          cadr_d  = bus.cmd_adr_i;
          cdat_d  = bus.cmd_dat_i;
          mask_d  = bus.cmd_mask_i;
          pcnt_d  = PCNT_W'(0);
          abort_d = 1'b0;
          state_d = S_STROBE;
        end
      end
      S_STROBE: begin
        if (op_q == OP_WR) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cap_d = bus.dat_i;
          if (op_q == OP_RD || hit_c) begin
            rsp_to_d = 1'b0;
            state_d  = S_RESP;
          end else begin
            pcnt_d = pcnt_inc_c;
            if (limit_c || abort_q || bus.abort_i) begin
              rsp_to_d = 1'b1;
              state_d  = S_RESP;
            end else if (POLL_GAP == 0) begin
              state_d = S_STROBE;
            end else begin
              cnt_d   = CNT_W'(POLL_GAP - 1);
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (bus.abort_i) begin
          rsp_to_d = 1'b1;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_W'(0)) begin
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d     = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    stb_d       = (state_d == S_STROBE);
    we_d        = stb_d && (op_d == OP_WR);
    adr_d       = stb_d ? cadr_d : ADR_W'(0);
    wdat_d      = we_d ? cdat_d : DAT_W'(0);
    rsp_valid_d = (state_d == S_RESP);
    rsp_dat_d   = rsp_valid_d ? cap_d : rsp_dat_q;
  end

  // State, command latch and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WR;
      cadr_q      <= '0;
      cdat_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      abort_q     <= 1'b0;
      cap_q       <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cadr_q      <= cadr_d;
      cdat_q      <= cdat_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      abort_q     <= abort_d;
      cap_q       <= cap_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  assign bus.cmd_ready_o   = ready_q;
  assign bus.busy_o        = busy_q;
  assign bus.stb_o         = stb_q;
  assign bus.we_o          = we_q;
  assign bus.adr_o         = adr_q;
  assign bus.dat_o         = wdat_q;
  assign bus.rsp_valid_o   = rsp_valid_q;
  assign bus.rsp_dat_o     = rsp_dat_q;
  assign bus.rsp_timeout_o = rsp_to_q;

endmodule
